// File: rtl/puf_response_collector.sv
// puf_response_collector
// Builds a RESP_BITS-wide PUF response from one challenge seed. Each response
// bit i drives challenge seed+i into the ring-oscillator core VOTES times,
// majority-votes the returned comparator bits, and counts bits whose votes
// were not unanimous. The finished word is offered to the host with a
// valid/ack handshake. A missing meas_done aborts the run with a sticky err.
//
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_start, i_seed     host run request and base challenge (sampled in IDLE)
//   o_busy              run in progress (ISSUE/WAIT/DECIDE/DONE)
//   o_resp              voted response word, bit i <-> challenge seed+i
//   o_resp_valid        o_resp is final; held until i_resp_ack
//   i_resp_ack          host consumes o_resp
//   o_unstable          count of non-unanimous bits, saturating at 255
//   o_err               sticky measurement timeout flag
//   o_challenge         challenge presented to the PUF core
//   o_meas_start        one-cycle measurement request
//   i_meas_done         one-cycle measurement completion
//   i_cmp_bit           comparator result, valid with i_meas_done
module puf_response_collector #(
  parameter int unsigned CHAL_W    = 8,
  parameter int unsigned RESP_BITS = 16,
  parameter int unsigned VOTES     = 5,
  parameter int unsigned TIMEOUT   = 1023
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic [CHAL_W-1:0]    i_seed,
  output logic                 o_busy,
  output logic [RESP_BITS-1:0] o_resp,
  output logic                 o_resp_valid,
  input  logic                 i_resp_ack,
  output logic [7:0]           o_unstable,
  output logic                 o_err,
  output logic [CHAL_W-1:0]    o_challenge,
  output logic                 o_meas_start,
  input  logic                 i_meas_done,
  input  logic                 i_cmp_bit
);

  localparam int unsigned VW = $clog2(VOTES + 1);
  localparam int unsigned IW = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ISSUE  = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_DECIDE = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]           r_state;
  logic [CHAL_W-1:0]    r_seed;
  logic [IW-1:0]        r_i;
  logic [VW-1:0]        r_v;
  logic [VW-1:0]        r_ones;
  logic [TW-1:0]        r_tmo;
  logic [RESP_BITS-1:0] r_resp;
  logic [7:0]           r_unstable;
  logic                 r_err;
  logic                 r_busy;
  logic                 r_resp_valid;
  logic [CHAL_W-1:0]    r_challenge;
  logic                 r_meas_start;

  logic [2:0]           w_state_nxt;
  logic [CHAL_W-1:0]    w_seed_nxt;
  logic [IW-1:0]        w_i_nxt;
  logic [VW-1:0]        w_v_nxt;
  logic [VW-1:0]        w_ones_nxt;
  logic [TW-1:0]        w_tmo_nxt;
  logic [RESP_BITS-1:0] w_resp_nxt;
  logic [7:0]           w_unstable_nxt;
  logic                 w_err_nxt;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and datapath update
  always_comb begin
    w_state_nxt    = r_state;
    w_seed_nxt     = r_seed;
    w_i_nxt        = r_i;
    w_v_nxt        = r_v;
    w_ones_nxt     = r_ones;
    w_tmo_nxt      = r_tmo;
    w_resp_nxt     = r_resp;
    w_unstable_nxt = r_unstable;
    w_err_nxt      = r_err;

    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_nxt    = S_ISSUE;
          w_seed_nxt     = i_seed;
          w_i_nxt        = '0;
          w_v_nxt        = '0;
          w_ones_nxt     = '0;
          w_unstable_nxt = '0;
          w_err_nxt      = 1'b0;
          w_resp_nxt     = '0;
        end
      end
      S_ISSUE: begin
        w_state_nxt = S_WAIT;
        w_tmo_nxt   = '0;
      end
      S_WAIT: begin
        // r_tmo counts completed WAIT cycles; meas_done wins on the last one
        if (i_meas_done) begin
          w_ones_nxt  = r_ones + VW'(i_cmp_bit);
          w_v_nxt     = r_v + VW'(1);
          w_state_nxt = (r_v == VW'(VOTES - 1)) ? S_DECIDE : S_ISSUE;
        end else if (r_tmo == TW'(TIMEOUT - 1)) begin
          // Abort: partial word and instability count are discarded
          w_err_nxt      = 1'b1;
          w_resp_nxt     = '0;
          w_unstable_nxt = '0;
          w_state_nxt    = S_IDLE;
        end else begin
          w_tmo_nxt = r_tmo + TW'(1);
        end
      end
      S_DECIDE: begin
        w_resp_nxt[r_i] = (r_ones > VW'(VOTES / 2));
        if ((r_ones != '0) && (r_ones != VW'(VOTES)) && (r_unstable != 8'hFF)) begin
          w_unstable_nxt = r_unstable + 8'd1;
        end
        w_ones_nxt  = '0;
        w_v_nxt     = '0;
        w_i_nxt     = r_i + IW'(1);
        w_state_nxt = (r_i == IW'(RESP_BITS - 1)) ? S_DONE : S_ISSUE;
      end
      S_DONE: begin
        if (i_resp_ack) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath and output registers; outputs follow the next state
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_seed       <= '0;
      r_i          <= '0;
      r_v          <= '0;
      r_ones       <= '0;
      r_tmo        <= '0;
      r_resp       <= '0;
      r_unstable   <= '0;
      r_err        <= 1'b0;
      r_busy       <= 1'b0;
      r_resp_valid <= 1'b0;
      r_challenge  <= '0;
      r_meas_start <= 1'b0;
    end else begin
      r_seed       <= w_seed_nxt;
      r_i          <= w_i_nxt;
      r_v          <= w_v_nxt;
      r_ones       <= w_ones_nxt;
      r_tmo        <= w_tmo_nxt;
      r_resp       <= w_resp_nxt;
      r_unstable   <= w_unstable_nxt;
      r_err        <= w_err_nxt;
      r_busy       <= (w_state_nxt != S_IDLE);
      r_resp_valid <= (w_state_nxt == S_DONE);
      r_meas_start <= (w_state_nxt == S_ISSUE);
      // Challenge wraps modulo 2^CHAL_W and is held through WAIT
      if (w_state_nxt == S_ISSUE) begin
        r_challenge <= w_seed_nxt + CHAL_W'(w_i_nxt);
      end
    end
  end

  assign o_busy       = r_busy;
  assign o_resp       = r_resp;
  assign o_resp_valid = r_resp_valid;
  assign o_unstable   = r_unstable;
  assign o_err        = r_err;
  assign o_challenge  = r_challenge;
  assign o_meas_start = r_meas_start;

endmodule

// File: tb/tb_puf_response_collector.sv
module tb_puf_response_collector;

  localparam int unsigned CHAL_W    = 8;
  localparam int unsigned RESP_BITS = 16;
  localparam int unsigned VOTES     = 5;
  localparam int unsigned TIMEOUT   = 1023;

  logic                 clk;
  logic                 rst;
  logic                 start;
  logic [CHAL_W-1:0]    seed;
  logic                 busy;
  logic [RESP_BITS-1:0] resp;
  logic                 resp_valid;
  logic                 resp_ack;
  logic [7:0]           unstable;
  logic                 err;
  logic [CHAL_W-1:0]    challenge;
  logic                 meas_start;
  logic                 meas_done;
  logic                 cmp_bit;

  int errors;
  int checks;
  int cyc;

  // Bench PUF core controls and recorded history
  int          mode;         // 0: cmp=challenge[0], 1: pat_a, 2: pat_b, 3: random
  int          lat;
  int          withhold_bit;
  int          meas_count;
  bit          stray_en;
  bit          stray_next;
  logic [4:0]  pat_a;
  logic [4:0]  pat_b;
  int          ones_bit [RESP_BITS];
  int          votes_bit[RESP_BITS];
  logic [7:0]  chal_log[$];
  int          issue_cyc[$];

  puf_response_collector #(
    .CHAL_W(CHAL_W), .RESP_BITS(RESP_BITS), .VOTES(VOTES), .TIMEOUT(TIMEOUT)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_seed(seed),
    .o_busy(busy), .o_resp(resp), .o_resp_valid(resp_valid),
    .i_resp_ack(resp_ack), .o_unstable(unstable), .o_err(err),
    .o_challenge(challenge), .o_meas_start(meas_start),
    .i_meas_done(meas_done), .i_cmp_bit(cmp_bit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural PUF core: answers each meas_start after a latency
  initial begin : core
    int k;
    int l;
    logic b;
    meas_done  = 1'b0;
    cmp_bit    = 1'b0;
    stray_next = 1'b0;
    forever begin
      @(negedge clk);
      meas_done = stray_next;
      if (stray_next) cmp_bit = 1'b1;
      stray_next = 1'b0;
      if (meas_start === 1'b1) begin
        k = meas_count;
        meas_count++;
        chal_log.push_back(challenge);
        issue_cyc.push_back(cyc);
        case (mode)
          0:       b = challenge[0];
          1:       b = pat_a[k % VOTES];
          2:       b = pat_b[k % VOTES];
          default: b = 1'($urandom_range(0, 1));
        endcase
        l = (mode == 3) ? int'($urandom_range(1, 4)) : lat;
        if (k / VOTES != withhold_bit) begin
          repeat (l) @(negedge clk);
          meas_done = 1'b1;
          cmp_bit   = b;
          if (k / VOTES < RESP_BITS) begin
            ones_bit[k / VOTES]  += int'(b);
            votes_bit[k / VOTES] += 1;
          end
          if (stray_en && (k % VOTES == VOTES - 1)) stray_next = 1'b1;
        end
      end
    end
  end

  task automatic clear_model();
    meas_count = 0;
    chal_log.delete();
    issue_cyc.delete();
    for (int i = 0; i < RESP_BITS; i++) begin
      ones_bit[i]  = 0;
      votes_bit[i] = 0;
    end
  endtask

  task automatic do_start(input logic [7:0] s);
    @(negedge clk);
    seed  = s;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_valid(input int bound, output int n);
    n = -1;
    for (int j = 0; j < bound; j++) begin
      if (resp_valid === 1'b1) begin
        n = j;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic do_ack();
    @(negedge clk);
    resp_ack = 1'b1;
    @(negedge clk);
    resp_ack = 1'b0;
  endtask

  // Reference: majority and unanimity from the recorded votes
  task automatic model(output logic [15:0] er, output int eu);
    er = '0;
    eu = 0;
    for (int i = 0; i < RESP_BITS; i++) begin
      er[i] = (2 * ones_bit[i] > VOTES);
      if (ones_bit[i] != 0 && ones_bit[i] != VOTES) eu++;
    end
    if (eu > 255) eu = 255;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, resp_valid, err, meas_start} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: busy/valid/err/meas_start=%b required 0000",
               {busy, resp_valid, err, meas_start});
    end
    checks++;
    if (resp !== 16'h0 || unstable !== 8'h0 || challenge !== 8'h0) begin
      errors++;
      $display("FAIL reset_data: resp=%h unstable=%0d challenge=%h required 0",
               resp, unstable, challenge);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b required 0", busy);
    end
  endtask

  task automatic test_fixed();
    int n;
    logic [15:0] er;
    int eu;
    mode = 0; lat = 3;
    clear_model();
    do_start(8'h00);
    checks++;
    if (busy !== 1'b1 || meas_start !== 1'b1 || challenge !== 8'h00) begin
      errors++;
      $display("FAIL fixed_first_issue: busy=%b meas_start=%b chal=%h required 1 1 00",
               busy, meas_start, challenge);
    end
    wait_valid(2000, n);
    checks++;
    if (n < 0) begin
      errors++;
      $display("FAIL fixed_timeout: resp_valid=%b required 1 within 2000 cycles", resp_valid);
    end else begin
      checks++;
      if (cyc - issue_cyc[0] != 336) begin
        errors++;
        $display("FAIL fixed_latency: got %0d cycles required 336", cyc - issue_cyc[0]);
      end
      model(er, eu);
      checks++;
      if (resp !== 16'hAAAA || resp !== er) begin
        errors++;
        $display("FAIL fixed_resp: got %h required AAAA (model %h)", resp, er);
      end
      checks++;
      if (unstable !== 8'd0) begin
        errors++;
        $display("FAIL fixed_unstable: got %0d required 0", unstable);
      end
    end
    do_ack();
  endtask

  task automatic test_majority();
    int n;
    mode = 1;
    clear_model();
    do_start(8'h00);
    wait_valid(2000, n);
    checks++;
    if (n < 0 || resp !== 16'hFFFF || unstable !== 8'd16) begin
      errors++;
      $display("FAIL majority_10101: resp=%h unstable=%0d valid=%b required FFFF 16 1",
               resp, unstable, resp_valid);
    end
    do_ack();
    mode = 2;
    clear_model();
    do_start(8'h00);
    wait_valid(2000, n);
    checks++;
    if (n < 0 || resp !== 16'h0000 || unstable !== 8'd16) begin
      errors++;
      $display("FAIL majority_00110: resp=%h unstable=%0d valid=%b required 0000 16 1",
               resp, unstable, resp_valid);
    end
    do_ack();
  endtask

  task automatic test_wrap();
    int n;
    int mism;
    logic [7:0] exp_c;
    mode = 0; lat = 3;
    clear_model();
    do_start(8'hF8);
    wait_valid(2000, n);
    mism = 0;
    for (int j = 0; j < RESP_BITS; j++) begin
      exp_c = 8'(8'hF8 + j);
      for (int v = 0; v < VOTES; v++) begin
        if (j * VOTES + v >= chal_log.size() || chal_log[j * VOTES + v] !== exp_c) mism++;
      end
    end
    checks++;
    if (n < 0 || chal_log.size() != RESP_BITS * VOTES || mism != 0) begin
      errors++;
      $display("FAIL wrap_challenges: count=%0d bad=%0d required %0d 0",
               chal_log.size(), mism, RESP_BITS * VOTES);
    end
    checks++;
    if (resp !== 16'hAAAA) begin
      errors++;
      $display("FAIL wrap_resp: got %h required AAAA", resp);
    end
    do_ack();
  endtask

  task automatic test_timeout();
    int n;
    int err_cyc;
    bit saw_valid;
    mode = 0; lat = 3; withhold_bit = 3;
    clear_model();
    do_start(8'h00);
    err_cyc = -1;
    saw_valid = 1'b0;
    for (int j = 0; j < TIMEOUT + 500; j++) begin
      if (resp_valid === 1'b1) saw_valid = 1'b1;
      if (err === 1'b1) begin
        err_cyc = cyc;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (err_cyc < 0) begin
      errors++;
      $display("FAIL timeout_err: err=%b required 1 within %0d cycles", err, TIMEOUT + 500);
    end else begin
      checks++;
      if (issue_cyc.size() < 16 || err_cyc - issue_cyc[15] != TIMEOUT + 1) begin
        errors++;
        $display("FAIL timeout_latency: issues=%0d cycles=%0d required %0d",
                 issue_cyc.size(), (issue_cyc.size() < 16) ? -1 : err_cyc - issue_cyc[15],
                 TIMEOUT + 1);
      end
      checks++;
      if (busy !== 1'b0 || resp !== 16'h0 || saw_valid) begin
        errors++;
        $display("FAIL timeout_abort: busy=%b resp=%h saw_valid=%b required 0 0000 0",
                 busy, resp, saw_valid);
      end
    end
    withhold_bit = -1;
    repeat (8) @(negedge clk);
    checks++;
    if (err !== 1'b1 || resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL timeout_sticky: err=%b valid=%b required 1 0", err, resp_valid);
    end
    clear_model();
    do_start(8'h00);
    checks++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL timeout_restart: err=%b busy=%b required 0 1", err, busy);
    end
    wait_valid(2000, n);
    checks++;
    if (n < 0 || resp !== 16'hAAAA || err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_rerun: resp=%h err=%b valid=%b required AAAA 0 1",
               resp, err, resp_valid);
    end
    do_ack();
  endtask

  task automatic test_handshake();
    int n;
    int mism;
    int bad_hold;
    logic [7:0] s;
    logic [15:0] er;
    logic [15:0] r0;
    logic [7:0] u0;
    int eu;
    mode = 3; stray_en = 1'b1;
    for (int it = 0; it < 3; it++) begin
      s = 8'($urandom);
      clear_model();
      do_start(s);
      repeat (40) @(negedge clk);
      seed = s ^ 8'h5A;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_valid(3000, n);
      model(er, eu);
      mism = 0;
      for (int j = 0; j < RESP_BITS; j++) begin
        if (votes_bit[j] != VOTES) mism++;
        for (int v = 0; v < VOTES; v++) begin
          if (j * VOTES + v >= chal_log.size() || chal_log[j * VOTES + v] !== 8'(s + j)) mism++;
        end
      end
      checks++;
      if (n < 0 || resp !== er || int'(unstable) != eu) begin
        errors++;
        $display("FAIL rand_resp[%0d]: resp=%h unstable=%0d required %h %0d", it, resp,
                 unstable, er, eu);
      end
      checks++;
      if (mism != 0) begin
        errors++;
        $display("FAIL rand_challenges[%0d]: bad=%0d required 0", it, mism);
      end
      r0 = resp;
      u0 = unstable;
      bad_hold = 0;
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        start = (c == 4);
        if (resp_valid !== 1'b1 || resp !== r0) bad_hold++;
      end
      start = 1'b0;
      checks++;
      if (bad_hold != 0) begin
        errors++;
        $display("FAIL hold_done[%0d]: unstable cycles=%0d required 0", it, bad_hold);
      end
      @(negedge clk);
      start = 1'b1;
      resp_ack = 1'b1;
      @(negedge clk);
      start = 1'b0;
      resp_ack = 1'b0;
      checks++;
      if (resp_valid !== 1'b0 || busy !== 1'b0 || resp !== r0 || unstable !== u0) begin
        errors++;
        $display("FAIL ack_start[%0d]: valid=%b busy=%b resp=%h unstable=%0d required 0 0 %h %0d",
                 it, resp_valid, busy, resp, unstable, r0, u0);
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || meas_start !== 1'b0) begin
        errors++;
        $display("FAIL ack_idle[%0d]: busy=%b meas_start=%b required 0 0", it, busy, meas_start);
      end
    end
    stray_en = 1'b0;
    mode = 0;
  endtask

  task automatic test_reset_midrun();
    int n;
    bit found;
    mode = 0; lat = 3;
    clear_model();
    do_start(8'h00);
    found = 1'b0;
    for (int j = 0; j < 2000; j++) begin
      if (meas_start === 1'b1 && challenge === 8'h07) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL midrun_bit7: challenge 07 not issued, chal=%h", challenge);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({busy, resp_valid, err, meas_start} !== 4'b0000 || resp !== 16'h0 ||
        unstable !== 8'h0 || challenge !== 8'h0) begin
      errors++;
      $display("FAIL midrun_reset: flags=%b resp=%h unstable=%0d chal=%h required 0000 0 0 0",
               {busy, resp_valid, err, meas_start}, resp, unstable, challenge);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || meas_start !== 1'b0) begin
      errors++;
      $display("FAIL midrun_idle: busy=%b meas_start=%b required 0 0", busy, meas_start);
    end
    clear_model();
    do_start(8'h00);
    wait_valid(2000, n);
    checks++;
    if (n < 0 || resp !== 16'hAAAA) begin
      errors++;
      $display("FAIL midrun_rerun: resp=%h valid=%b required AAAA 1", resp, resp_valid);
    end
    do_ack();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    cyc = 0;
    rst = 1'b1;
    start = 1'b0;
    seed = '0;
    resp_ack = 1'b0;
    mode = 0;
    lat = 3;
    withhold_bit = -1;
    stray_en = 1'b0;
    pat_a = 5'b10101;
    pat_b = 5'b01100;
    meas_count = 0;
    test_reset();
    test_fixed();
    test_majority();
    test_wrap();
    test_timeout();
    test_handshake();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/puf_response_collector.md
# puf_response_collector

Downstream stage of the ring-oscillator PUF core. Turns a single challenge seed into a multi-bit PUF response. For each response bit it drives a derived challenge into the core, runs repeated measurements, and majority-votes the per-measurement comparator bit. It packs the voted bits into a response word, counts unstable bits, and hands the word to the host with a valid/ack handshake.

## Interface

Parameters:
- CHAL_W, 8: challenge width driven to the PUF core.
- RESP_BITS, 16: response bits per run (2..64).
- VOTES, 5: measurements per bit; must be odd, 1..15.
- TIMEOUT, 1023: maximum cycles spent waiting for one meas_done.

Ports:
- Reset is synchronous and active-high.
- clk  in  1  single clock for the block.
- rst  in  1  synchronous active-high reset.
- start  in  1  host request; sampled only in IDLE.
- seed  in  CHAL_W  base challenge; latched on an accepted start.
- busy  out  1  high from the cycle after an accepted start until return to IDLE.
- resp  out  RESP_BITS  voted response; bit i belongs to challenge seed+i.
- resp_valid  out  1  resp is final; held until resp_ack.
- resp_ack  in  1  host consumes resp.
- unstable  out  8  number of bits whose votes were not unanimous; saturates at 255.
- err  out  1  sticky timeout flag; cleared by the next accepted start or by rst.
- challenge  out  CHAL_W  challenge presented to the PUF core.
- meas_start  out  1  one-cycle pulse that requests one measurement.
- meas_done  in  1  one-cycle pulse; the measurement is complete and cmp_bit is valid.
- cmp_bit  in  1  1 when count1 > count2; a tie reports 0.

## Operation

- States: IDLE, ISSUE, WAIT, DECIDE, DONE.
- **IDLE**
  - start=1 latches seed and clears bit index i, vote counter v, ones, unstable, err and resp.
  - The state moves to ISSUE.
- **ISSUE** (one cycle)
  - challenge = seed + i, mod 2^CHAL_W.
  - meas_start = 1.
  - The state moves to WAIT and the timeout counter is cleared.
- **WAIT**
  - challenge is held.
  - On meas_done: ones += cmp_bit and v += 1.
    - If v reaches VOTES, go to DECIDE.
    - Otherwise go back to ISSUE.
  - If the timeout counter reaches TIMEOUT without meas_done:
    - set err=1;
    - discard partial results (resp stays 0, resp_valid stays 0);
    - go to IDLE.
- **DECIDE** (one cycle)
  - resp[i] = (ones > VOTES/2).
  - If ones is neither 0 nor VOTES, unstable increments (saturating at 255).
  - Clear ones and v, then i += 1.
  - If i was RESP_BITS-1, go to DONE; otherwise go to ISSUE.
- **DONE**
  - resp_valid = 1.
  - On resp_ack: resp_valid drops next cycle, go to IDLE.
  - resp and unstable keep their values until the next accepted start.
- Widths:
  - v and ones are $clog2(VOTES+1) bits.
  - i is $clog2(RESP_BITS) bits.
  - The challenge sum wraps modulo 2^CHAL_W; no carry is kept.
- Boundary conditions:
  - start outside IDLE is ignored, including in DONE and when it arrives in the same cycle as resp_ack.
  - resp_ack outside DONE is ignored.
  - meas_done arriving in ISSUE, DECIDE, IDLE or DONE is ignored.
  - rst in any state returns to IDLE within one cycle and aborts any run in progress.

## Timing

- Reset values: busy=0, resp=0, resp_valid=0, unstable=0, err=0, challenge=0, meas_start=0. State is IDLE.
- All outputs are registered.
- busy and the first meas_start both assert the cycle after start is sampled (IDLE→ISSUE edge).
- Per measurement: 1 ISSUE cycle + L WAIT cycles, where L ≥ 1 is the number of cycles up to and including meas_done.
- Per bit: VOTES·(1+L) + 1 cycles.
- resp_valid rises on the first DONE cycle, which is the cycle after the last DECIDE.
- On timeout, err rises and busy falls in the same cycle, TIMEOUT WAIT cycles after the ISSUE.
- Minimum spacing between meas_start pulses is 2 cycles.

## Test plan

- **Fixed response.** Bench core: L=3, cmp_bit = challenge[0]. Apply seed=0x00, defaults.
  - resp = 0xAAAA, unstable = 0, resp_valid after 16·(5·4+1) = 336 cycles from ISSUE entry.
- **Majority vote.** Bench returns 1,0,1,0,1 for every bit.
  - resp = 0xFFFF, unstable = 16.
  - Then return 0,0,1,1,0: resp = 0x0000, unstable = 16.
- **Challenge wrap.** seed=0xF8, RESP_BITS=16.
  - Challenges observed are 0xF8..0xFF then 0x00..0x07, each presented exactly VOTES times.
- **Timeout.** Bench withholds meas_done on bit 3.
  - After TIMEOUT cycles: err=1, busy=0, resp_valid never asserts.
  - A new start clears err and the run completes normally.
- **Handshake and ignored inputs.**
  - Hold resp_ack low 10 cycles in DONE: resp_valid stays 1 and resp is stable.
  - start pulsed while busy and while in DONE is ignored.
  - Stray meas_done in DECIDE is not counted.
- **Reset mid-run.** Assert rst during WAIT of bit 7.
  - Next cycle all outputs are at reset values and the state is IDLE.
  - A following start with seed=0x00 produces 0xAAAA.
